// File: rtl/sntc_ldpc_bitflip_decoder.sv
// sntc_ldpc_bitflip_decoder
// Hard-decision bit-flipping decoder for the NR_2_0_4 codeword (208 bits,
// 168 checks, systematic info bits 0..39). Each round computes the syndrome
// and the per-bit unsatisfied-check counts, then inverts every bit whose
// count equals the maximum, until the syndrome clears or MAX_ITER rounds ran.
// Check-node connectivity is held in edge_valid()/edge_bit(): check r joins
// info bit (r mod 40) and parity bit 40+r; replacing those two functions
// swaps in a different parity-check table without touching the datapath.
// Optional feature macro: SNTC_LDPC_DEC_STUCK_DETECT_EN (early abort when
// the syndrome weight stops improving).
module sntc_ldpc_bitflip_decoder #(
    parameter int MM       = 'h0a8,
    parameter int NN       = 'h0d0,
    parameter int cmax     = 'h017,
    parameter int rmax     = 'h00a,
    parameter int SUM_MM   = $clog2(MM + 1),
    parameter int UCNT_W   = $clog2(rmax + 1),
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NN-1:0]        y_nr_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NN-1:0]        y_nr_cword,
    output logic [NN-MM-1:0]     y_nr_dec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 dec_ok,
    output logic [ITER_W-1:0]    iter_cnt,
    output logic [SUM_MM-1:0]    syn_wt
);

    localparam int KK    = NN - MM;
    localparam int IDX_W = $clog2(NN);

    typedef enum logic [1:0] {IDLE, CHECK, FLIP, DONE} state_t;

    state_t                        state;
    logic [NN-1:0]                 word;
    logic [ITER_W-1:0]             iter;
    logic [NN-1:0][UCNT_W-1:0]     u_reg;

    logic [MM-1:0]                 s_next;
    logic [SUM_MM-1:0]             wt_next;
    logic [NN-1:0][UCNT_W-1:0]     u_next;
    logic [UCNT_W-1:0]             umax;
    logic [NN-1:0]                 flip_mask;
    logic                          chk_done;
    logic                          chk_ok;

    // Edge k of check r exists only for the first two slots.
    function automatic logic edge_valid(input int k);
        return (k < 2);
    endfunction

    // Codeword bit index attached to edge k of check r.
    function automatic logic [IDX_W-1:0] edge_bit(input int r, input int k);
        if (k == 0) begin
            return IDX_W'(r % KK);
        end
        return IDX_W'(KK + r);
    endfunction

    assign in_ready = (state == IDLE) && !clr;
    assign y_nr_dec = y_nr_cword[NN-MM-1:0];

`ifdef SNTC_LDPC_DEC_STUCK_DETECT_EN
    logic [SUM_MM-1:0] prev_wt;
    logic              stalled_once;
    logic              no_gain;
    logic              stuck;

    assign no_gain = (iter != '0) && (wt_next >= prev_wt);
    assign stuck   = no_gain && stalled_once && (iter >= ITER_W'(2)) && (wt_next != '0);
`endif

    // Syndrome, its weight and per-bit unsatisfied counts of the current word.
    always_comb begin
        s_next  = '0;
        wt_next = '0;
        u_next  = '0;
        for (int r = 0; r < MM; r++) begin
            for (int k = 0; k < cmax; k++) begin
                if (edge_valid(k)) begin
                    s_next[r] = s_next[r] ^ word[edge_bit(r, k)];
                end
            end
            wt_next = wt_next + SUM_MM'(s_next[r]);
            for (int k = 0; k < cmax; k++) begin
                if (edge_valid(k) && s_next[r]) begin
                    u_next[edge_bit(r, k)] = u_next[edge_bit(r, k)] + UCNT_W'(1);
                end
            end
        end
    end

    // Largest registered unsatisfied count and the set of bits that reach it.
    always_comb begin
        umax      = '0;
        flip_mask = '0;
        for (int j = 0; j < NN; j++) begin
            if (u_reg[j] > umax) begin
                umax = u_reg[j];
            end
        end
        for (int j = 0; j < NN; j++) begin
            flip_mask[j] = (u_reg[j] == umax);
        end
    end

    // Decide whether the CHECK round ends the decode, and with what verdict.
    always_comb begin
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        if (wt_next == '0) begin
            chk_done = 1'b1;
            chk_ok   = 1'b1;
        end else if (iter == ITER_W'(MAX_ITER)) begin
            chk_done = 1'b1;
`ifdef SNTC_LDPC_DEC_STUCK_DETECT_EN
        end else if (stuck) begin
            chk_done = 1'b1;
`endif
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            word       <= '0;
            iter       <= '0;
            u_reg      <= '0;
            out_valid  <= 1'b0;
            dec_ok     <= 1'b0;
            iter_cnt   <= '0;
            syn_wt     <= '0;
            y_nr_cword <= '0;
`ifdef SNTC_LDPC_DEC_STUCK_DETECT_EN
            prev_wt      <= '0;
            stalled_once <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        word  <= y_nr_in;
                        iter  <= '0;
                        state <= CHECK;
`ifdef SNTC_LDPC_DEC_STUCK_DETECT_EN
                        stalled_once <= 1'b0;
`endif
                    end
                end
                CHECK: begin
                    u_reg <= u_next;
`ifdef SNTC_LDPC_DEC_STUCK_DETECT_EN
                    prev_wt      <= wt_next;
                    stalled_once <= no_gain;
`endif
                    if (chk_done) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        dec_ok     <= chk_ok;
                        y_nr_cword <= word;
                        iter_cnt   <= iter;
                        syn_wt     <= wt_next;
                    end else begin
                        state <= FLIP;
                    end
                end
                FLIP: begin
                    word <= word ^ flip_mask;
                    if (iter != ITER_W'(MAX_ITER)) begin
                        iter <= iter + ITER_W'(1);
                    end
                    state <= CHECK;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
